// File: rtl/xbar_rob_pkg.sv
// xbar_rob_pkg: default sizes, bank one-hot decode and per-bank return beat type for xbar_rob_gen
package xbar_rob_pkg;
  localparam int NUM_BANKS_D = 4;
  localparam int CH_ID_W_D   = 2;
  localparam int ROB_DEPTH_D = 8;
  localparam int ROB_PTR_W_D = $clog2(ROB_DEPTH_D);
  localparam int DATA_W_D    = 128;
  localparam int KOF_AW_D    = 4;
  localparam int MAX_BANKS   = 64;
  typedef struct packed {
    logic                   valid;
    logic [CH_ID_W_D-1:0]   ch_id;
    logic [ROB_PTR_W_D-1:0] rob_num;
    logic [DATA_W_D-1:0]    data;
  } bank_beat_t;
  function automatic logic [MAX_BANKS-1:0] bank_sel(input int unsigned id);
    return MAX_BANKS'(1) << id;
  endfunction
endpackage

// File: rtl/rob_bank_buffer.sv
// rob_bank_buffer: one bank's ROB slots with valid bits, read pointer and overwrite detect
// Ports: wr_i/wr_idx_i/wr_data_i slot write, pop_i releases slot rd_ptr and advances it,
// head_valid_o/head_data_o slot at rd_ptr, ovf_o write hit an occupied slot (dropped),
// rd_ptr_o present only with XBAR_ROB_BYPASS_EN.
module rob_bank_buffer #(
  parameter int ROB_DEPTH = 8,
  parameter int ROB_PTR_W = 3,
  parameter int DATA_W    = 128
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_i,
  input  logic [ROB_PTR_W-1:0] wr_idx_i,
  input  logic [DATA_W-1:0]    wr_data_i,
  input  logic                 pop_i,
  output logic                 head_valid_o,
  output logic [DATA_W-1:0]    head_data_o,
  output logic                 ovf_o
`ifdef XBAR_ROB_BYPASS_EN
  , output logic [ROB_PTR_W-1:0] rd_ptr_o
`endif
);
  logic [DATA_W-1:0]    mem_q [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] vld_q, vld_d;
  logic [ROB_PTR_W-1:0] rp_q;
  logic                 wr_ok;
  assign wr_ok        = wr_i & ~vld_q[wr_idx_i];
  assign ovf_o        = wr_i & vld_q[wr_idx_i];
  assign head_valid_o = vld_q[rp_q];
  assign head_data_o  = mem_q[rp_q];
`ifdef XBAR_ROB_BYPASS_EN
  assign rd_ptr_o     = rp_q;
`endif
  // popped slot is valid, so a same-cycle write to it is an overwrite and never reaches wr_ok
  always_comb begin
    vld_d = vld_q;
    if (pop_i) vld_d[rp_q] = 1'b0;
    if (wr_ok) vld_d[wr_idx_i] = 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      vld_q <= '0;
      rp_q  <= '0;
    end else begin
      vld_q <= vld_d;
      rp_q  <= rp_q + ROB_PTR_W'(pop_i);
    end
  always_ff @(posedge clk_i)
    if (wr_ok) mem_q[wr_idx_i] <= wr_data_i;
endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: synchronous FIFO, 2**AW entries of DW bits, registered full flag
// Ports: push_i/din_i write, pop_i read (dout_o is the head), empty_o/full_o status,
// push_err_o push while full without a pop, pop_err_o pop while empty.
module sync_fifo #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          push_err_o,
  output logic          pop_err_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, do_push, do_pop;
  assign do_pop     = pop_i & ~empty_o;
  // a pop frees the slot first, so push while full is accepted in that cycle
  assign do_push    = push_i & (~full_q | do_pop);
  assign cnt_d      = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout_o     = mem_q[rp_q];
  assign empty_o    = cnt_q == '0;
  assign full_o     = full_q;
  assign push_err_o = push_i & ~do_push;
  assign pop_err_o  = pop_i & empty_o;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      wp_q   <= wp_q + AW'(do_push);
      rp_q   <= rp_q + AW'(do_pop);
      cnt_q  <= cnt_d;
      full_q <= cnt_d == (AW+1)'(2**AW);
    end
  always_ff @(posedge clk_i)
    if (do_push) mem_q[wp_q] <= din_i;
endmodule

// File: rtl/xbar_rob_gen.sv
// xbar_rob_gen: per-channel reorder stage returning bank read data in issue order
// Ports: req_kickoff_i/req_bank_id_i record issue order, kof_full_o order FIFO full,
// bank_* flattened per-bank return buses, bank_pop_o one-hot slot release,
// rtn_valid_o/rtn_ready_i/rtn_data_o registered ordered return, err_o sticky protocol error.
// Option: XBAR_ROB_BYPASS_EN forwards a write to the awaited head slot straight to the output.
module xbar_rob_gen
  import xbar_rob_pkg::*;
#(
  parameter int CHANNEL_ID = 0,
  parameter int NUM_BANKS  = NUM_BANKS_D,
  parameter int BANK_ID_W  = $clog2(NUM_BANKS),
  parameter int CH_ID_W    = CH_ID_W_D,
  parameter int ROB_DEPTH  = ROB_DEPTH_D,
  parameter int ROB_PTR_W  = $clog2(ROB_DEPTH),
  parameter int DATA_W     = DATA_W_D,
  parameter int KOF_AW     = KOF_AW_D
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_kickoff_i,
  input  logic [BANK_ID_W-1:0]           req_bank_id_i,
  output logic                           kof_full_o,
  input  logic [NUM_BANKS-1:0]           bank_valid_i,
  input  logic [NUM_BANKS*CH_ID_W-1:0]   bank_ch_id_i,
  input  logic [NUM_BANKS*ROB_PTR_W-1:0] bank_rob_num_i,
  input  logic [NUM_BANKS*DATA_W-1:0]    bank_data_i,
  output logic [NUM_BANKS-1:0]           bank_pop_o,
  output logic                           rtn_valid_o,
  input  logic                           rtn_ready_i,
  output logic [DATA_W-1:0]              rtn_data_o,
  output logic                           err_o
);
  logic [NUM_BANKS-1:0] wr, hv, ovf;
  logic [DATA_W-1:0]    hd [NUM_BANKS];
  logic [DATA_W-1:0]    wd [NUM_BANKS];
  logic [ROB_PTR_W-1:0] wi [NUM_BANKS];
  logic [BANK_ID_W-1:0] head;
  logic [DATA_W-1:0]    pop_data, rtn_data_q;
  logic                 empty, push_err, pop_err, slot_ok, pop, byp, rtn_valid_q, err_q;
  sync_fifo #(.AW(KOF_AW), .DW(BANK_ID_W)) u_kof (
    .clk_i(clk_i), .rst_ni(rst_ni), .push_i(req_kickoff_i), .pop_i(pop), .din_i(req_bank_id_i),
    .dout_o(head), .empty_o(empty), .full_o(kof_full_o), .push_err_o(push_err), .pop_err_o(pop_err)
  );
  // head bank is expected and the output register can take a new beat
  assign slot_ok = ~empty & (~rtn_valid_q | rtn_ready_i);
`ifdef XBAR_ROB_BYPASS_EN
  logic [ROB_PTR_W-1:0] rp [NUM_BANKS];
  assign byp = slot_ok & ~hv[head] & wr[head] & (wi[head] == rp[head]);
`else
  assign byp = 1'b0;
`endif
  assign pop        = slot_ok & (hv[head] | byp);
  assign pop_data   = byp ? wd[head] : hd[head];
  assign bank_pop_o = pop ? NUM_BANKS'(bank_sel(32'(head))) : '0;
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic sel;
    assign sel   = head == BANK_ID_W'(b);
    assign wr[b] = bank_valid_i[b] & (bank_ch_id_i[b*CH_ID_W +: CH_ID_W] == CH_ID_W'(CHANNEL_ID));
    assign wi[b] = bank_rob_num_i[b*ROB_PTR_W +: ROB_PTR_W];
    assign wd[b] = bank_data_i[b*DATA_W +: DATA_W];
    rob_bank_buffer #(.ROB_DEPTH(ROB_DEPTH), .ROB_PTR_W(ROB_PTR_W), .DATA_W(DATA_W)) u_buf (
      .clk_i(clk_i), .rst_ni(rst_ni), .wr_i(wr[b] & ~(byp & sel)), .wr_idx_i(wi[b]),
      .wr_data_i(wd[b]), .pop_i(pop & sel), .head_valid_o(hv[b]), .head_data_o(hd[b]), .ovf_o(ovf[b])
`ifdef XBAR_ROB_BYPASS_EN
      , .rd_ptr_o(rp[b])
`endif
    );
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      rtn_valid_q <= 1'b0;
      rtn_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      if (pop) begin
        rtn_valid_q <= 1'b1;
        rtn_data_q  <= pop_data;
      end else if (rtn_ready_i) rtn_valid_q <= 1'b0;
      err_q <= err_q | (|ovf) | push_err | pop_err;
    end
  assign rtn_valid_o = rtn_valid_q;
  assign rtn_data_o  = rtn_data_q;
  assign err_o       = err_q;
endmodule

// File: doc/xbar_rob_gen.md
Name: xbar_rob_gen

Overview:
Parametrised per-channel reorder stage sitting between the bank-side scheduler return buses and one channel's read-return port. It records the bank order of issued reads in a keep-order FIFO and buffers out-of-order bank returns in per-bank ROB slots indexed by rob_num. It returns data strictly in issue order through a registered valid/ready output with backpressure. It generalises bank count, ROB depth, data width and channel-ID width, and adds overflow/protocol error reporting.

Parameters:
CHANNEL_ID, 0, channel this instance serves; compared against bank ch_id.
NUM_BANKS, 4, number of bank return buses (power of two, >=2).
BANK_ID_W, $clog2(NUM_BANKS), bank id width.
CH_ID_W, 2, channel id width on bank buses.
ROB_DEPTH, 8, slots per bank ROB (power of two).
ROB_PTR_W, $clog2(ROB_DEPTH), rob_num width.
DATA_W, 128, return data width.
KOF_AW, 4, keep-order FIFO address width (depth 2**KOF_AW).

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_kickoff_i  in  1  read issued for this channel; push bank id into keep-order FIFO
req_bank_id_i  in  BANK_ID_W  target bank of issued read
kof_full_o  out  1  keep-order FIFO full; requester must not kick off
bank_valid_i  in  NUM_BANKS  per-bank return valid
bank_ch_id_i  in  NUM_BANKS*CH_ID_W  flattened per-bank channel id
bank_rob_num_i  in  NUM_BANKS*ROB_PTR_W  flattened per-bank ROB slot
bank_data_i  in  NUM_BANKS*DATA_W  flattened per-bank data
bank_pop_o  out  NUM_BANKS  one-hot slot release pulse to bank (credit return)
rtn_valid_o  out  1  ordered return data valid
rtn_ready_i  in  1  consumer ready
rtn_data_o  out  DATA_W  ordered return data
err_o  out  1  sticky protocol error (slot overwrite, push when full, pop when empty)

Behaviour:
- Reset is async assert, sync deassert by the system. All state clears: FIFO empty, all slot valid bits 0, all per-bank read pointers 0, rtn_valid_o=0, rtn_data_o=0, bank_pop_o=0, err_o=0, kof_full_o=0. Reset mid-operation discards all in-flight data; no pops are issued for discarded slots.
- Write: bank b writes when bank_valid_i[b] and ch_id==CHANNEL_ID. Data lands in slot rob_num of bank b; the slot valid bit sets next cycle. A write to an already-valid slot is dropped, and err_o sets.
- Each bank has an independent read pointer rd_ptr[b]. It advances by 1 (mod ROB_DEPTH) only on pop of bank b.
- Head = keep-order FIFO dout. Pop condition: FIFO non-empty AND slot rd_ptr[head] of bank head valid AND (rtn_valid_o==0 OR rtn_ready_i).
- On pop, in the same cycle: FIFO pops, the slot valid bit clears, rd_ptr[head] increments, bank_pop_o[head]=1 (combinational, one-hot, one pulse per pop).
- Output register: loaded on pop with slot data, so rtn_valid_o=1 next cycle. It holds valid and data stable while rtn_ready_i=0. It clears when ready and no new pop. Back-to-back pops give 1 beat/cycle when ready held high.
- Latency: bank write at cycle N -> rtn_valid_o at N+2 (FIFO head already present).
- Simultaneous write to a non-head slot and pop of the head: both occur. A write to the slot being popped the same cycle is impossible (slot valid), so it is an overwrite error.
- Keep-order FIFO: push while full is ignored and sets err_o. Push and pop in the same cycle while full is legal (pop first). kof_full_o is registered from FIFO state.
- Wrap-around: rd_ptr wraps ROB_DEPTH-1 -> 0. Pointer width is exactly ROB_PTR_W.

Optional Feature:
XBAR_ROB_BYPASS_EN: when defined, a bank write that targets slot rd_ptr[head] of the head bank, with the pop conditions otherwise met, bypasses the storage. The data loads into the output register that cycle and the slot valid bit is never set. Latency becomes N+1. Without the macro there is no bypass and latency is N+2.

Decomposition:
- Package xbar_rob_pkg: default parameter constants, a bank-select decode function, and a typedef for a per-bank return beat struct (valid, ch_id, rob_num, data).
- One sub-module, rob_bank_buffer: slot storage, valid bits, rd_ptr, overwrite detect. It is instantiated NUM_BANKS times via generate.
- The keep-order FIFO reuses the existing sync_fifo with AW=KOF_AW and DW=BANK_ID_W.

Test Plan:
- In-order single bank: kickoffs to bank0 x3, returns rob 0,1,2 at cycles 5,6,7 with ready=1 -> rtn_valid_o at 7,8,9 with data in order; bank_pop_o[0] pulses at 6,7,8.
- Cross-bank reorder: kickoff bank2 then bank0; bank0 returns first (cycle 5), bank2 at cycle 9 -> bank2 data out at 11, bank0 data out at 12; bank2 pointer to 1, bank0 pointer to 1, others remain 0.
- Backpressure: rtn_ready_i=0 for 4 cycles with 3 returns buffered -> rtn_data_o stable; only 1 pop until ready rises, then 1 beat/cycle.
- Wrap: 20 sequential reads to bank3 with ROB_DEPTH=8 -> all returned in order; rd_ptr wraps twice; no err_o.
- Errors: write to a valid slot -> data dropped, err_o=1 next cycle and sticky; kickoff while kof_full_o=1 -> ignored, err_o=1.
- Reset mid-stream: assert rst_ni low with 2 slots valid and rtn_valid_o=1 -> all outputs 0 immediately; after release, a fresh kickoff/return completes normally. Also re-run with XBAR_ROB_BYPASS_EN defined and check N+1 latency.
